// File: rtl/ap_ctrl_txn_profiler.sv
// Cycle profiler for an ap_ctrl_hs kernel: one {id, latency, iters, stalls} record per transaction into a FWFT FIFO.
// Optional PROF_TIMESTAMP_EN appends the start-cycle timestamp as the LSB field.
module ap_ctrl_txn_profiler #(
  parameter int CNT_W      = 32,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_continue,
  input  logic              iter_start_enable,
  input  logic              iter_start_block,
  input  logic              finish,
  output logic              rec_valid,
  input  logic              rec_ready,
`ifdef PROF_TIMESTAMP_EN
  output logic [ID_W+4*CNT_W-1:0] rec_data,
`else
  output logic [ID_W+3*CNT_W-1:0] rec_data,
`endif
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy,
  output logic              finish_ack
);
`ifdef PROF_TIMESTAMP_EN
  localparam int REC_W = ID_W + 4*CNT_W;
`else
  localparam int REC_W = ID_W + 3*CNT_W;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_CONT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] latency, iter_count, stall_cycles;
  logic [CNT_W-1:0] lat_nxt, iter_nxt, stall_nxt;
  logic [ID_W-1:0]  txn_id;
  logic             push, pop, full, wr_en, drop;
  logic [REC_W-1:0] rec_nxt;
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             unused;

  assign unused = ap_ready;

`ifdef PROF_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_cnt, ts_start, ts_nxt;
`endif

  always_comb begin
    state_nxt = state;
    lat_nxt   = latency;
    iter_nxt  = iter_count;
    stall_nxt = stall_cycles;
    push      = 1'b0;
`ifdef PROF_TIMESTAMP_EN
    ts_nxt    = ts_start;
`endif
    case (state)
      IDLE: begin
        if (finish) state_nxt = DRAIN;
        else if (ap_start) begin
          state_nxt = RUN;
          // latency spans start cycle up to, not including, the done cycle
          lat_nxt   = ap_done ? '0 : CNT_W'(1);
          iter_nxt  = '0;
          stall_nxt = '0;
`ifdef PROF_TIMESTAMP_EN
          ts_nxt    = ts_cnt;
`endif
          if (ap_done) begin
            if (ap_continue) begin
              push      = 1'b1;
              state_nxt = IDLE;
            end else state_nxt = WAIT_CONT;
          end
        end
      end
      RUN: begin
        if (iter_start_enable && !iter_start_block && !(&iter_count)) iter_nxt = iter_count + 1'b1;
        if (iter_start_enable && iter_start_block && !(&stall_cycles)) stall_nxt = stall_cycles + 1'b1;
        if (!ap_done) begin
          if (!(&latency)) lat_nxt = latency + 1'b1;
        end else if (ap_continue) begin
          push      = 1'b1;
          state_nxt = finish ? DRAIN : IDLE;
        end else state_nxt = WAIT_CONT;
      end
      WAIT_CONT: begin
        if (ap_continue) begin
          push      = 1'b1;
          state_nxt = finish ? DRAIN : IDLE;
        end
      end
      DRAIN: if (!finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PROF_TIMESTAMP_EN
  assign rec_nxt = {txn_id, lat_nxt, iter_nxt, stall_nxt, ts_nxt};
`else
  assign rec_nxt = {txn_id, lat_nxt, iter_nxt, stall_nxt};
`endif

  assign rec_valid = (cnt != '0);
  assign rec_data  = rec_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);
  assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
  assign pop       = rec_valid && rec_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign cnt_nxt   = cnt + (AW+1)'(wr_en) - (AW+1)'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      latency      <= '0;
      iter_count   <= '0;
      stall_cycles <= '0;
      txn_id       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      drop_cnt     <= '0;
      finish_ack   <= 1'b0;
    end else begin
      state        <= state_nxt;
      latency      <= lat_nxt;
      iter_count   <= iter_nxt;
      stall_cycles <= stall_nxt;
      if (push) txn_id <= txn_id + 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt          <= cnt_nxt;
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      finish_ack   <= (state == DRAIN) && finish && (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= rec_nxt;
  end

`ifdef PROF_TIMESTAMP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_cnt   <= '0;
      ts_start <= '0;
    end else begin
      ts_cnt   <= ts_cnt + 1'b1;
      ts_start <= ts_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// Randomized + directed bench for ap_ctrl_txn_profiler against a transaction-level model (default build).
module tb_ap_ctrl_txn_profiler;
  localparam int REC_W = 8 + 3*32;

  logic clock = 1'b0;
  logic reset, ap_start, ap_ready, ap_done, ap_continue, en, blk, finish, rec_ready;
  logic rec_valid, busy, finish_ack;
  logic [REC_W-1:0] rec_data;
  logic [15:0] drop_cnt;

  always #5 clock = ~clock;

  ap_ctrl_txn_profiler dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .iter_start_enable(en),
    .iter_start_block(blk), .finish(finish), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_data(rec_data), .drop_cnt(drop_cnt),
    .busy(busy), .finish_ack(finish_ack)
  );

  int checks = 0, failures = 0;

  // transaction-level model: start/done cycle stamps, loop tallies, record queue
  logic [REC_W-1:0] q[$];
  int m_drops, m_cyc, m_start, m_dcyc, m_it, m_st;
  logic [7:0] m_id;
  bit m_in, m_done, m_drain, m_ack;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit pop, push, was_drain;
    logic [REC_W-1:0] r;
    m_cyc++;
    if (reset) begin
      q.delete(); m_drops = 0; m_id = 0; m_in = 0; m_done = 0; m_drain = 0; m_ack = 0;
      return;
    end
    pop = (q.size() != 0) && rec_ready;
    push = 0;
    was_drain = m_drain;
    r = '0;
    if (m_drain) begin
      if (!finish) m_drain = 0;
    end else if (!m_in) begin
      if (finish) m_drain = 1;
      else if (ap_start) begin
        m_in = 1; m_start = m_cyc; m_it = 0; m_st = 0;
        m_done = ap_done; m_dcyc = m_cyc;
        push = ap_done && ap_continue;
      end
    end else begin
      if (!m_done) begin
        if (en && !blk) m_it++;
        if (en && blk) m_st++;
        if (ap_done) begin m_done = 1; m_dcyc = m_cyc; end
      end
      push = m_done && ap_continue;
    end
    if (push) begin
      r = {m_id, 32'(m_dcyc - m_start), 32'(m_it), 32'(m_st)};
      m_id++; m_in = 0; m_done = 0; m_drain = finish;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < 4) q.push_back(r);
      else m_drops++;
    end
    m_ack = was_drain && finish && (q.size() == 0);
  endtask

  task automatic check();
    chk("rec_valid", rec_valid, q.size() != 0);
    if (q.size() != 0) chk("rec_data", rec_data, q[0]);
    chk("busy", busy, m_in || m_drain);
    chk("drop_cnt", drop_cnt, m_drops);
    chk("finish_ack", finish_ack, m_ack);
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
    check();
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  // start, lat-1 loop cycles (n_it free then n_st blocked), done; continue after cw cycles
  task automatic txn(int lat, int n_it, int n_st, int cw, bit rdy_done);
    ap_start = 1; tick(); ap_start = 0;
    for (int i = 1; i < lat; i++) begin
      en = (i <= n_it + n_st); blk = (i > n_it); tick();
    end
    en = 0; blk = 0; ap_done = 1;
    for (int w = 0; w < cw; w++) begin ap_continue = 0; tick(); end
    ap_continue = 1;
    if (rdy_done) rec_ready = 1;
    tick();
    ap_done = 0;
  endtask

  initial begin
    reset = 1; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1;
    en = 0; blk = 0; finish = 0; rec_ready = 1;
    m_cyc = 0; m_drops = 0; m_id = 0;
    tick(); tick();
    reset = 0;
    chk("rst_rec_valid", rec_valid, 1'b0);
    chk("rst_rec_data", rec_data, '0);
    chk("rst_busy", busy, 1'b0);
    repeat (3) tick();

    // basic: latency 10, 5 iterations, no stalls
    txn(10, 5, 0, 0, 1);
    chk("t1_rec", rec_data, {8'd0, 32'd10, 32'd5, 32'd0});
    tick();
    chk("t1_single_cycle", rec_valid, 1'b0);

    // 3 of 8 enabled cycles blocked
    txn(10, 5, 3, 0, 1);
    chk("t2_rec", rec_data, {8'd1, 32'd10, 32'd5, 32'd3});
    tick();

    // continue held low 4 cycles after done
    txn(10, 2, 0, 4, 1);
    chk("t3_rec", rec_data, {8'd2, 32'd10, 32'd2, 32'd0});
    tick();

    // overflow: 6 txns into a 4-deep FIFO, then a push coinciding with a pop
    do_reset();
    rec_ready = 0;
    repeat (6) txn(3, 1, 0, 0, 0);
    chk("t4_drops", drop_cnt, 16'd2);
    chk("t4_head_id", rec_data[103:96], 8'd0);
    txn(3, 1, 0, 0, 1);
    chk("t4_drops_kept", drop_cnt, 16'd2);
    chk("t4_head_id1", rec_data[103:96], 8'd1);
    repeat (5) tick();

    // finish mid-run with 2 records queued
    do_reset();
    rec_ready = 0;
    txn(3, 1, 0, 0, 0);
    txn(3, 1, 0, 0, 0);
    ap_start = 1; tick(); ap_start = 0;
    en = 1; repeat (3) tick();
    finish = 1; repeat (2) tick();
    ap_done = 1; tick(); ap_done = 0; en = 0;
    chk("t5_busy_drain", busy, 1'b1);
    rec_ready = 1;
    tick(); tick();
    chk("t5_ack_early", finish_ack, 1'b0);
    tick();
    chk("t5_ack", finish_ack, 1'b1);
    finish = 0; tick();
    chk("t5_ack_clr", finish_ack, 1'b0);
    chk("t5_idle", busy, 1'b0);

    // reset mid-run with FIFO non-empty
    rec_ready = 0;
    txn(3, 1, 0, 0, 0);
    ap_start = 1; tick(); ap_start = 0; tick(); tick();
    do_reset();
    chk("t6_valid", rec_valid, 1'b0);
    chk("t6_drops", drop_cnt, 16'd0);
    chk("t6_busy", busy, 1'b0);
    rec_ready = 1;
    txn(4, 2, 1, 0, 1);
    chk("t6_rec", rec_data, {8'd0, 32'd4, 32'd2, 32'd1});
    tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom % 150) == 0;
      ap_start    = ($urandom % 4) == 0;
      ap_ready    = $urandom % 2;
      ap_done     = ($urandom % 5) == 0;
      ap_continue = ($urandom % 10) < 7;
      en          = ($urandom % 10) < 6;
      blk         = ($urandom % 3) == 0;
      rec_ready   = ($urandom % 3) != 0;
      if (($urandom % 40) == 0) finish = ~finish;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
